// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// Producer side: flush, wr_en, wr_data in; wr_full, almost_full, overflow out.
// Consumer side: rd_en in; rd_data, rd_valid, rd_empty, almost_empty,
// underflow, count out.
// The slave modport is the FIFO's view; the master modport is the user's view.
interface sync_fifo_flags_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_full;
  logic                  almost_full;
  logic                  overflow;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_empty;
  logic                  almost_empty;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_full, almost_full, overflow,
    input  rd_data, rd_valid, rd_empty, almost_empty, underflow, count
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_full, almost_full, overflow,
    output rd_data, rd_valid, rd_empty, almost_empty, underflow, count
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and synchronous flush.
// FWFT=1 presents the head word combinationally (show-ahead);
// FWFT=0 registers the popped word and strobes rd_valid for one cycle.
// Ports: clk, reset (sync, active-low), fifo (sync_fifo_flags_if.slave).
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned FWFT       = 1
) (
  input logic               clk,
  input logic               reset,
  sync_fifo_flags_if.slave  fifo
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      count_c;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic                  overflow_q;
  logic                  underflow_q;

  // Occupancy and flags decode straight from the registered pointers.
  always_comb begin
    count_c  = wr_ptr - rd_ptr;
    full_c   = (count_c == PTR_W'(DEPTH));
    empty_c  = (count_c == '0);
    wr_acc_c = fifo.wr_en && !full_c;
    rd_acc_c = fifo.rd_en && !empty_c;
  end

  assign fifo.count        = count_c;
  assign fifo.wr_full      = full_c;
  assign fifo.rd_empty     = empty_c;
  assign fifo.almost_full  = (count_c >= PTR_W'(AF_LEVEL));
  assign fifo.almost_empty = (count_c <= PTR_W'(AE_LEVEL));
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && !fifo.flush && wr_acc_c) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= fifo.wr_data;
    end
  end

  // Pointers and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (fifo.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo.wr_en && full_c)  overflow_q  <= 1'b1;
      if (fifo.rd_en && empty_c) underflow_q <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_show_ahead
      // Head word is always visible; rd_en only acknowledges the pop.
      assign fifo.rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
      assign fifo.rd_valid = !empty_c;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // Popped word is captured; rd_data holds when nothing is popped.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (fifo.flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc_c;
          if (rd_acc_c) rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
      end

      assign fifo.rd_data  = rd_data_q;
      assign fifo.rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one show-ahead and one registered-read instance
// share identical stimulus and are compared every cycle against a queue model.
module tb_sync_fifo_flags;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 1;

  logic clk;
  logic reset;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_sa ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_rg ();

  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF),
                    .AE_LEVEL(AE), .FWFT(1)) u_sa (
    .clk(clk), .reset(reset), .fifo(if_sa));

  sync_fifo_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF),
                    .AE_LEVEL(AE), .FWFT(0)) u_rg (
    .clk(clk), .reset(reset), .fifo(if_rg));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  // Reference model: plain queue plus sticky bits and the registered-read view.
  logic [DW-1:0] q [$];
  bit            m_ovf;
  bit            m_unf;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic f, input logic we,
                              input logic [DW-1:0] wd, input logic re);
    bit full;
    bit empty;
    if (!r) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rvalid = 0; m_rdata = '0;
    end else if (f) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rvalid = 0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      m_rvalid = 0;
      if (we && full)  m_ovf = 1;
      if (re && empty) m_unf = 1;
      if (re && !empty) begin
        m_rdata  = q.pop_front();
        m_rvalid = 1;
      end
      if (we && !full) q.push_back(wd);
    end
  endtask

  // One clock cycle of stimulus; returns 1 ns after the edge with the model updated.
  task automatic cyc(input logic r, input logic f, input logic we,
                     input logic [DW-1:0] wd, input logic re);
    reset = r;
    if_sa.flush = f; if_sa.wr_en = we; if_sa.wr_data = wd; if_sa.rd_en = re;
    if_rg.flush = f; if_rg.wr_en = we; if_rg.wr_data = wd; if_rg.rd_en = re;
    @(posedge clk);
    model_update(r, f, we, wd, re);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    cyc(1'b1, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      int n;
      n = q.size();
      chk("sa_count",   32'(if_sa.count),        32'(n));
      chk("rg_count",   32'(if_rg.count),        32'(n));
      chk("sa_empty",   32'(if_sa.rd_empty),     32'(n == 0));
      chk("sa_full",    32'(if_sa.wr_full),      32'(n == DEPTH));
      chk("sa_afull",   32'(if_sa.almost_full),  32'(n >= AF));
      chk("sa_aempty",  32'(if_sa.almost_empty), 32'(n <= AE));
      chk("rg_empty",   32'(if_rg.rd_empty),     32'(n == 0));
      chk("rg_full",    32'(if_rg.wr_full),      32'(n == DEPTH));
      chk("rg_afull",   32'(if_rg.almost_full),  32'(n >= AF));
      chk("rg_aempty",  32'(if_rg.almost_empty), 32'(n <= AE));
      chk("sa_ovf",     32'(if_sa.overflow),     32'(m_ovf));
      chk("sa_unf",     32'(if_sa.underflow),    32'(m_unf));
      chk("rg_ovf",     32'(if_rg.overflow),     32'(m_ovf));
      chk("rg_unf",     32'(if_rg.underflow),    32'(m_unf));
      chk("sa_valid",   32'(if_sa.rd_valid),     32'(n != 0));
      if (n != 0) chk("sa_data", 32'(if_sa.rd_data), 32'(q[0]));
      chk("rg_valid",   32'(if_rg.rd_valid),     32'(m_rvalid));
      chk("rg_data",    32'(if_rg.rd_data),      32'(m_rdata));
    end
  end

  initial begin
    int wp;
    int rp;
    logic r_i;
    logic f_i;
    logic we_i;
    logic re_i;

    // 1. Reset and fill
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    armed = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 16'h1111, 1'b1);
    chk("rst_count",  32'(if_sa.count), 32'd0);
    chk("rst_empty",  32'(if_sa.rd_empty), 32'd1);
    chk("rst_full",   32'(if_sa.wr_full), 32'd0);
    chk("rst_aempty", 32'(if_sa.almost_empty), 32'd1);
    chk("rst_afull",  32'(if_sa.almost_full), 32'd0);
    chk("rst_rvalid", 32'(if_rg.rd_valid), 32'd0);
    chk("rst_rdata",  32'(if_rg.rd_data), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      wr(16'(k));
      chk("fill_count",  32'(if_sa.count), 32'(k));
      chk("fill_aempty", 32'(if_sa.almost_empty), 32'(k < 2));
      chk("fill_afull",  32'(if_sa.almost_full), 32'(k >= 6));
      chk("fill_full",   32'(if_sa.wr_full), 32'(k == 8));
    end
    wr(16'h0009);
    chk("ovf_set",   32'(if_sa.overflow), 32'd1);
    chk("ovf_count", 32'(if_sa.count), 32'd8);

    // 2. Drain
    for (int k = 1; k <= 8; k++) begin
      chk("drain_sa_data", 32'(if_sa.rd_data), 32'(k));
      rd();
      chk("drain_rg_valid", 32'(if_rg.rd_valid), 32'd1);
      chk("drain_rg_data",  32'(if_rg.rd_data), 32'(k));
    end
    chk("drain_empty", 32'(if_sa.rd_empty), 32'd1);
    rd();
    chk("unf_set", 32'(if_sa.underflow), 32'd1);
    wr(16'h0BEE);
    chk("wrap_sa_data", 32'(if_sa.rd_data), 32'h0BEE);
    rd();
    chk("wrap_rg_data", 32'(if_rg.rd_data), 32'h0BEE);

    // 3. Simultaneous read and write
    for (int k = 0; k < 4; k++) wr(16'(16'h0100 + k));
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 16'(16'h0200 + k), 1'b1);
      chk("rw_count", 32'(if_sa.count), 32'd4);
      chk("rw_rg_data", 32'(if_rg.rd_data),
          32'(k < 4 ? 16'h0100 + k : 16'h0200 + k - 4));
    end
    for (int k = 0; k < 4; k++) wr(16'(16'h0300 + k));
    chk("rw_full", 32'(if_sa.wr_full), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b1);
    chk("rw_full_count", 32'(if_sa.count), 32'd7);
    for (int k = 0; k < 7; k++) rd();
    cyc(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1);
    chk("rw_empty_count", 32'(if_sa.count), 32'd1);
    chk("rw_empty_data",  32'(if_sa.rd_data), 32'hBEEF);
    rd();

    // 4. Registered-read mode
    wr(16'hA5A5);
    rd();
    chk("rg_pulse_valid", 32'(if_rg.rd_valid), 32'd1);
    chk("rg_pulse_data",  32'(if_rg.rd_data), 32'hA5A5);
    idle();
    chk("rg_hold_valid", 32'(if_rg.rd_valid), 32'd0);
    chk("rg_hold_data",  32'(if_rg.rd_data), 32'hA5A5);

    // 5. Flush at count 5 with overflow set
    for (int k = 0; k < 9; k++) wr(16'(16'h0400 + k));
    for (int k = 0; k < 3; k++) rd();
    chk("pre_flush_count", 32'(if_sa.count), 32'd5);
    chk("pre_flush_ovf",   32'(if_sa.overflow), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 16'h7777, 1'b0);
    chk("flush_count", 32'(if_sa.count), 32'd0);
    chk("flush_empty", 32'(if_sa.rd_empty), 32'd1);
    chk("flush_ovf",   32'(if_sa.overflow), 32'd0);
    idle();
    chk("flush_dropped", 32'(if_sa.count), 32'd0);

    // 6. Mid-operation reset
    for (int k = 0; k < 3; k++) wr(16'(16'h0500 + k));
    rd();
    cyc(1'b1, 1'b0, 1'b1, 16'h0600, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0700, 1'b1);
    chk("mrst_count",  32'(if_sa.count), 32'd0);
    chk("mrst_empty",  32'(if_sa.rd_empty), 32'd1);
    chk("mrst_aempty", 32'(if_sa.almost_empty), 32'd1);
    chk("mrst_rvalid", 32'(if_rg.rd_valid), 32'd0);
    chk("mrst_rdata",  32'(if_rg.rd_data), 32'd0);

    // Randomized traffic with phases biased toward filling or draining
    wp = 2; rp = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        wp = $urandom_range(0, 4);
        rp = 4 - wp;
      end
      r_i  = ($urandom_range(0, 299) != 0);
      f_i  = ($urandom_range(0, 99) == 0);
      we_i = ($urandom_range(0, 3) < wp);
      re_i = ($urandom_range(0, 3) < rp);
      cyc(r_i, f_i, we_i, 16'($urandom), re_i);
    end
    idle();
    @(negedge clk);
    armed = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
